id_ex_stage: RTL and testbench

//  ID/EX pipeline register feeding the ALU. Captures decoded operands and controls each cycle.

---
 rtl/id_ex_stage_pkg.sv | 32 +++
 rtl/id_ex_stage_alu_control.sv | 31 +++
 rtl/id_ex_stage.sv | 142 ++++++++++++++
 tb/tb_id_ex_stage.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX stage: ALU selects, ALUOp codes, control bit
// positions and forwarding-source selects.
package id_ex_stage_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_AND    = 3'b111;
    localparam logic [2:0] F3_OR     = 3'b110;

    // Bit positions inside the 5-bit {RegWrite,MemRead,MemWrite,MemtoReg,Branch} bundle
    localparam int CTRL_REGWRITE = 4;
    localparam int CTRL_MEMREAD  = 3;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_BRANCH   = 0;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_alu_control.sv
// Combinational ALUOp/funct decode into the 4-bit ALU select; zero latency.
// Unsupported funct3 or ALUOp values select ALU_NOP, which makes the ALU yield 0.
module id_ex_stage_alu_control
    import id_ex_stage_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_is_rtype,
    output logic [3:0] o_alu_sel
);

    always_comb begin
        o_alu_sel = ALU_NOP;
        case (i_alu_op)
            ALUOP_ADD: o_alu_sel = ALU_ADD;
            ALUOP_SUB: o_alu_sel = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // funct7b5 only means subtract on R-type; I-type uses bit 30 as immediate
                    F3_ADDSUB: o_alu_sel = (i_is_rtype && i_funct7b5) ? ALU_SUB : ALU_ADD;
                    F3_AND:    o_alu_sel = ALU_AND;
                    F3_OR:     o_alu_sel = ALU_OR;
                    default:   o_alu_sel = ALU_NOP;
                endcase
            end
            default: o_alu_sel = ALU_NOP;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU decode, EX/MEM + MEM/WB operand forwarding and load-use stall;
// one-cycle latency, flush beats stall beats capture, and a flush or stall loads a bubble.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int N     = 32,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [N-1:0]     id_pc,
    input  logic [N-1:0]     id_rs1_data,
    input  logic [N-1:0]     id_rs2_data,
    input  logic [N-1:0]     id_imm,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic [1:0]       id_alu_op,
    input  logic [2:0]       id_funct3,
    input  logic             id_funct7b5,
    input  logic             id_is_rtype,
    input  logic             id_alu_src,
    input  logic [4:0]       id_ctrl,
    input  logic             flush,
    input  logic             exmem_regwrite,
    input  logic [REG_W-1:0] exmem_rd,
    input  logic [N-1:0]     exmem_result,
    input  logic             memwb_regwrite,
    input  logic [REG_W-1:0] memwb_rd,
    input  logic [N-1:0]     memwb_result,
    output logic             stall,
    output logic             ex_valid,
    output logic [N-1:0]     ex_pc,
    output logic [N-1:0]     ex_alu_a,
    output logic [N-1:0]     ex_alu_b,
    output logic [N-1:0]     ex_store_data,
    output logic [3:0]       ex_alu_sel,
    output logic [REG_W-1:0] ex_rd,
    output logic [4:0]       ex_ctrl
);

    logic [3:0]       w_alu_sel;
    logic             w_stall;
    fwd_sel_e         w_fwd_a;
    fwd_sel_e         w_fwd_b;
    logic [N-1:0]     w_rs1_fwd;
    logic [N-1:0]     w_rs2_fwd;

    logic             r_valid;
    logic [N-1:0]     r_pc;
    logic [N-1:0]     r_rs1_data;
    logic [N-1:0]     r_rs2_data;
    logic [N-1:0]     r_imm;
    logic [REG_W-1:0] r_rs1;
    logic [REG_W-1:0] r_rs2;
    logic [REG_W-1:0] r_rd;
    logic [3:0]       r_alu_sel;
    logic             r_alu_src;
    logic [4:0]       r_ctrl;

    id_ex_stage_alu_control u_alu_control (
        .i_alu_op   (id_alu_op),
        .i_funct3   (id_funct3),
        .i_funct7b5 (id_funct7b5),
        .i_is_rtype (id_is_rtype),
        .o_alu_sel  (w_alu_sel)
    );

    // A load in EX cannot feed its value to the instruction right behind it
    assign w_stall = r_valid & r_ctrl[CTRL_MEMREAD] & (r_rd != '0)
                   & ((r_rd == id_rs1) | (r_rd == id_rs2)) & id_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_alu_sel  <= ALU_ADD;
            r_alu_src  <= 1'b0;
            r_ctrl     <= '0;
        end else if (flush || w_stall) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else begin
            r_valid    <= id_valid;
            r_pc       <= id_pc;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_rd       <= id_rd;
            r_alu_sel  <= w_alu_sel;
            r_alu_src  <= id_alu_src;
            r_ctrl     <= id_ctrl;
        end
    end

    // The younger producer (EX/MEM) wins; x0 is hardwired and never forwarded
    always_comb begin
        w_fwd_a = FWD_REG;
        w_fwd_b = FWD_REG;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == r_rs1))
            w_fwd_a = FWD_EXMEM;
        else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == r_rs1))
            w_fwd_a = FWD_MEMWB;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == r_rs2))
            w_fwd_b = FWD_EXMEM;
        else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == r_rs2))
            w_fwd_b = FWD_MEMWB;
    end

    always_comb begin
        case (w_fwd_a)
            FWD_EXMEM: w_rs1_fwd = exmem_result;
            FWD_MEMWB: w_rs1_fwd = memwb_result;
            default:   w_rs1_fwd = r_rs1_data;
        endcase
        case (w_fwd_b)
            FWD_EXMEM: w_rs2_fwd = exmem_result;
            FWD_MEMWB: w_rs2_fwd = memwb_result;
            default:   w_rs2_fwd = r_rs2_data;
        endcase
    end

    assign stall         = w_stall;
    assign ex_valid      = r_valid;
    assign ex_pc         = r_pc;
    assign ex_alu_a      = w_rs1_fwd;
    assign ex_alu_b      = r_alu_src ? r_imm : w_rs2_fwd;
    assign ex_store_data = w_rs2_fwd;
    assign ex_alu_sel    = r_alu_sel;
    assign ex_rd         = r_rd;
    assign ex_ctrl       = r_ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: decode vector table, directed hazard/forwarding/reset sequences,
// then random traffic checked against a slot-level reference model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [1:0]  id_alu_op;
    logic [2:0]  id_funct3;
    logic        id_funct7b5, id_is_rtype, id_alu_src;
    logic [4:0]  id_ctrl;
    logic        flush;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        stall, ex_valid;
    logic [31:0] ex_pc, ex_alu_a, ex_alu_b, ex_store_data;
    logic [3:0]  ex_alu_sel;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_ctrl;

    id_ex_stage #(.N(32), .REG_W(5)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_op(id_alu_op), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
        .id_is_rtype(id_is_rtype), .id_alu_src(id_alu_src), .id_ctrl(id_ctrl), .flush(flush),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b),
        .ex_store_data(ex_store_data), .ex_alu_sel(ex_alu_sel), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_op = 0; id_funct3 = 0;
        id_funct7b5 = 0; id_is_rtype = 0; id_alu_src = 0; id_ctrl = 0; flush = 0;
        exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
        memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    // Reference model: one EX slot record, updated per edge from the architectural rules
    typedef struct {
        logic        valid;
        logic [31:0] pc, a, b, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  sel;
        logic        src;
        logic [4:0]  ctrl;
    } slot_t;
    slot_t m;

    function automatic logic [3:0] m_sel(input logic [1:0] op, input logic [2:0] f3,
                                         input logic b5, input logic rt);
        if (op == 2'd0) return 4'b0010;
        if (op == 2'd1) return 4'b0110;
        if (op == 2'd3) return 4'b1111;
        if (f3 == 3'd0) return (rt && b5) ? 4'b0110 : 4'b0010;
        if (f3 == 3'd7) return 4'b0000;
        if (f3 == 3'd6) return 4'b0001;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_fwd(input logic [4:0] rs, input logic [31:0] regv);
        if (rs == 0) return regv;
        if (exmem_regwrite && exmem_rd == rs) return exmem_result;
        if (memwb_regwrite && memwb_rd == rs) return memwb_result;
        return regv;
    endfunction

    function automatic logic m_stall();
        return m.valid && m.ctrl[3] && m.rd != 0 && id_valid && (m.rd == id_rs1 || m.rd == id_rs2);
    endfunction

    task automatic check_model();
        logic [31:0] st;
        st = m_fwd(m.rs2, m.b);
        check("rnd_stall",  32'(stall), 32'(m_stall()));
        check("rnd_valid",  32'(ex_valid), 32'(m.valid));
        check("rnd_ctrl",   32'(ex_ctrl), 32'(m.ctrl));
        check("rnd_pc",     ex_pc, m.pc);
        check("rnd_rd",     32'(ex_rd), 32'(m.rd));
        check("rnd_sel",    32'(ex_alu_sel), 32'(m.sel));
        check("rnd_alu_a",  ex_alu_a, m_fwd(m.rs1, m.a));
        check("rnd_store",  ex_store_data, st);
        check("rnd_alu_b",  ex_alu_b, m.src ? m.imm : st);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [2:0] f3;
        logic       b5;
        logic       rt;
        logic [3:0] exp_sel;
    } dec_vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        dec_vec_t vecs[9];
        logic     exp_stall;

        idle_inputs();
        rst = 1;
        #2 rst = 0;
        #10;
        check("reset_valid", 32'(ex_valid), 32'd0);
        check("reset_ctrl",  32'(ex_ctrl), 32'd0);
        check("reset_sel",   32'(ex_alu_sel), 32'b0010);
        check("reset_stall", 32'(stall), 32'd0);
        rst = 1;
        tick();

        vecs[0] = '{2'd2, 3'd0, 1'b1, 1'b1, 4'b0110};
        vecs[1] = '{2'd2, 3'd6, 1'b0, 1'b0, 4'b0001};
        vecs[2] = '{2'd2, 3'd4, 1'b0, 1'b1, 4'b1111};
        vecs[3] = '{2'd2, 3'd0, 1'b1, 1'b0, 4'b0010};
        vecs[4] = '{2'd2, 3'd0, 1'b0, 1'b1, 4'b0010};
        vecs[5] = '{2'd2, 3'd7, 1'b0, 1'b1, 4'b0000};
        vecs[6] = '{2'd0, 3'd7, 1'b1, 1'b1, 4'b0010};
        vecs[7] = '{2'd1, 3'd0, 1'b0, 1'b0, 4'b0110};
        vecs[8] = '{2'd3, 3'd0, 1'b0, 1'b0, 4'b1111};
        for (int i = 0; i < 9; i++) begin
            idle_inputs();
            id_valid = 1; id_rd = 5'(i + 1);
            id_alu_op = vecs[i].op; id_funct3 = vecs[i].f3;
            id_funct7b5 = vecs[i].b5; id_is_rtype = vecs[i].rt;
            tick();
            check($sformatf("decode_sel[%0d]", i), 32'(ex_alu_sel), 32'(vecs[i].exp_sel));
            check($sformatf("decode_rd[%0d]", i),  32'(ex_rd), i + 1);
        end

        // Forwarding priority on operand A
        idle_inputs();
        id_valid = 1; id_rs1 = 5; id_rs1_data = 32'h11; id_rs2 = 6; id_rs2_data = 32'h66;
        tick();
        id_valid = 0;
        exmem_regwrite = 1; exmem_rd = 5; exmem_result = 32'hAA;
        memwb_regwrite = 1; memwb_rd = 5; memwb_result = 32'hBB;
        #1 check("fwd_exmem_wins", ex_alu_a, 32'hAA);
        check("fwd_b_unmatched", ex_store_data, 32'h66);
        exmem_regwrite = 0;
        #1 check("fwd_memwb", ex_alu_a, 32'hBB);
        exmem_regwrite = 1; exmem_rd = 0; memwb_rd = 0;
        #1 check("fwd_none", ex_alu_a, 32'h11);

        // x0 is never forwarded even when a producer claims rd=0
        idle_inputs();
        id_valid = 1; id_rs1 = 0; id_rs1_data = 32'h22;
        tick();
        exmem_regwrite = 1; exmem_rd = 0; exmem_result = 32'hAA;
        memwb_regwrite = 1; memwb_rd = 0; memwb_result = 32'hBB;
        #1 check("fwd_x0", ex_alu_a, 32'h22);

        // Immediate path vs forwarded store data
        idle_inputs();
        id_valid = 1; id_alu_src = 1; id_imm = 32'hFFFF_FFFC;
        id_rs1 = 4; id_rs1_data = 32'h44; id_rs2 = 3; id_rs2_data = 32'h99;
        tick();
        memwb_regwrite = 1; memwb_rd = 3; memwb_result = 32'h10;
        #1 check("imm_alu_b", ex_alu_b, 32'hFFFF_FFFC);
        check("imm_store", ex_store_data, 32'h10);
        check("imm_alu_a", ex_alu_a, 32'h44);

        // Load-use: lw x7 in EX, add x8,x7,x1 in ID
        idle_inputs();
        id_valid = 1; id_rd = 7; id_rs1 = 2; id_ctrl = 5'b11010;
        tick();
        idle_inputs();
        id_valid = 1; id_rs1 = 7; id_rs2 = 1; id_rd = 8; id_ctrl = 5'b10000;
        id_alu_op = 2'd2; id_is_rtype = 1;
        #1 check("lu_stall", 32'(stall), 32'd1);
        tick();
        check("lu_bubble_valid", 32'(ex_valid), 32'd0);
        check("lu_bubble_ctrl",  32'(ex_ctrl), 32'd0);
        check("lu_stall_clear",  32'(stall), 32'd0);
        tick();
        check("lu_add_valid", 32'(ex_valid), 32'd1);
        check("lu_add_rd",    32'(ex_rd), 32'd8);
        check("lu_add_ctrl",  32'(ex_ctrl), 32'b10000);

        // A load to x0 never stalls
        idle_inputs();
        id_valid = 1; id_rd = 0; id_ctrl = 5'b11010;
        tick();
        id_rs1 = 0; id_rd = 9; id_ctrl = 5'b10000;
        #1 check("lu_x0_nostall", 32'(stall), 32'd0);

        // Flush kills the slot
        idle_inputs();
        id_valid = 1; id_rd = 9; id_ctrl = 5'b10000; flush = 1;
        tick();
        check("flush_valid", 32'(ex_valid), 32'd0);
        check("flush_ctrl",  32'(ex_ctrl), 32'd0);

        // Asynchronous reset in the middle of a cycle
        idle_inputs();
        id_valid = 1; id_pc = 32'h40; id_ctrl = 5'b11111; id_alu_op = 2'd1;
        tick();
        check("pre_rst_valid", 32'(ex_valid), 32'd1);
        #2 rst = 0;
        #1 check("midrst_valid", 32'(ex_valid), 32'd0);
        check("midrst_ctrl", 32'(ex_ctrl), 32'd0);
        check("midrst_sel",  32'(ex_alu_sel), 32'b0010);
        check("midrst_pc",   ex_pc, 32'd0);
        #1 rst = 1;
        idle_inputs();
        id_valid = 1; id_pc = 32'h100; id_rd = 3;
        tick();
        check("postrst_valid", 32'(ex_valid), 32'd1);
        check("postrst_pc",    ex_pc, 32'h100);

        // Random traffic against the slot model, starting from a clean reset
        idle_inputs();
        rst = 0;
        #2 rst = 1;
        m = '{valid: 1'b0, pc: 32'd0, a: 32'd0, b: 32'd0, imm: 32'd0, rs1: 5'd0, rs2: 5'd0,
              rd: 5'd0, sel: 4'b0010, src: 1'b0, ctrl: 5'd0};
        tick();
        for (int i = 0; i < 400; i++) begin
            id_valid       = ($urandom_range(0, 3) != 0);
            id_pc          = $urandom;
            id_rs1_data    = $urandom;
            id_rs2_data    = $urandom;
            id_imm         = $urandom;
            id_rs1         = 5'($urandom_range(0, 7));
            id_rs2         = 5'($urandom_range(0, 7));
            id_rd          = 5'($urandom_range(0, 7));
            id_alu_op      = 2'($urandom_range(0, 3));
            id_funct3      = 3'($urandom_range(0, 7));
            id_funct7b5    = 1'($urandom_range(0, 1));
            id_is_rtype    = 1'($urandom_range(0, 1));
            id_alu_src     = 1'($urandom_range(0, 1));
            id_ctrl        = 5'($urandom_range(0, 31));
            flush          = ($urandom_range(0, 9) == 0);
            exmem_regwrite = 1'($urandom_range(0, 1));
            exmem_rd       = 5'($urandom_range(0, 7));
            exmem_result   = $urandom;
            memwb_regwrite = 1'($urandom_range(0, 1));
            memwb_rd       = 5'($urandom_range(0, 7));
            memwb_result   = $urandom;
            #1 check_model();
            @(posedge clk);
            exp_stall = m_stall();
            if (flush || exp_stall) begin
                m.valid = 0;
                m.ctrl  = 0;
            end else begin
                m.valid = id_valid;  m.pc  = id_pc;       m.a   = id_rs1_data;
                m.b     = id_rs2_data; m.imm = id_imm;    m.rs1 = id_rs1;
                m.rs2   = id_rs2;    m.rd  = id_rd;       m.src = id_alu_src;
                m.ctrl  = id_ctrl;
                m.sel   = m_sel(id_alu_op, id_funct3, id_funct7b5, id_is_rtype);
            end
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
